// File: rtl/midi_voice_scheduler.sv
// MIDI Note On/Off parser with running status and oldest-steal voice allocation.
// Drives per-slot active/note/velocity registers for the LED and tone stages.
module midi_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int CHANNEL    = 0,
    parameter int OMNI       = 0,
    parameter int AGE_W      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_byte_valid,
    input  logic [7:0]              i_byte_data,
    input  logic                    i_panic,
    output logic [NUM_VOICES-1:0]   o_voice_active,
    output logic [7*NUM_VOICES-1:0] o_voice_note,
    output logic [7*NUM_VOICES-1:0] o_voice_vel,
    output logic                    o_note_event,
    output logic                    o_steal
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2} state_t;

    state_t                r_state;
    logic [7:0]            r_status;
    logic [6:0]            r_d1;
    logic [NUM_VOICES-1:0] r_active;
    logic [6:0]            r_note [NUM_VOICES];
    logic [6:0]            r_vel  [NUM_VOICES];
    logic [AGE_W-1:0]      r_age  [NUM_VOICES];
    logic                  r_note_event;
    logic                  r_steal;

    logic                  w_is_data;
    logic                  w_is_sys;
    logic                  w_is_rt;
    logic                  w_chan_ok;
    logic                  w_note_msg;
    logic                  w_exec;
    logic                  w_on;
    logic [NUM_VOICES-1:0] w_hits;
    logic                  w_hit_any;
    logic                  w_free_any;
    logic [IDX_W-1:0]      w_hit_idx;
    logic [IDX_W-1:0]      w_free_idx;
    logic [IDX_W-1:0]      w_old_idx;
    logic [AGE_W-1:0]      w_old_age;
    logic [IDX_W-1:0]      w_tgt;
    logic                  w_steal;

    assign w_is_data  = ~i_byte_data[7];
    assign w_is_sys   = (i_byte_data[7:3] == 5'b11110);
    assign w_is_rt    = (i_byte_data[7:3] == 5'b11111);
    assign w_chan_ok  = (OMNI != 0) || (r_status[3:0] == 4'(CHANNEL));
    assign w_note_msg = (r_status[7:5] == 3'b100);
    assign w_exec     = i_byte_valid && w_is_data && (r_state == WAIT_D2) && w_note_msg && w_chan_ok;
    assign w_on       = r_status[4] && (i_byte_data[6:0] != 7'd0);

    // Lowest-index hit and free slot; oldest slot with ties resolved to the lowest index.
    always_comb begin
        w_hits     = '0;
        w_hit_any  = 1'b0;
        w_hit_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_old_idx  = '0;
        w_old_age  = r_age[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_hits[i] = r_active[i] && (r_note[i] == r_d1);
        end
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                w_hit_any = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_active[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (r_age[i] > w_old_age) begin
                w_old_age = r_age[i];
                w_old_idx = IDX_W'(i);
            end
        end
        w_steal = !w_hit_any && !w_free_any;
        w_tgt   = w_hit_any ? w_hit_idx : (w_free_any ? w_free_idx : w_old_idx);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= NO_STATUS;
            r_status <= 8'd0;
            r_d1     <= 7'd0;
        end else if (i_byte_valid) begin
            if (w_is_rt) begin
                r_state <= r_state;
            end else if (w_is_sys) begin
                r_state  <= NO_STATUS;
                r_status <= 8'd0;
            end else if (!w_is_data) begin
                r_status <= i_byte_data;
                r_state  <= WAIT_D1;
            end else begin
                unique case (r_state)
                    WAIT_D1: begin
                        r_d1    <= i_byte_data[6:0];
                        // Program change / channel pressure carry a single data byte.
                        r_state <= (r_status[7:5] == 3'b110) ? WAIT_D1 : WAIT_D2;
                    end
                    WAIT_D2: r_state <= WAIT_D1;
                    default: r_state <= NO_STATUS;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active     <= '0;
            r_note_event <= 1'b0;
            r_steal      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            r_note_event <= w_exec && !i_panic;
            r_steal      <= w_exec && !i_panic && w_on && w_steal;
            if (i_panic) begin
                r_active <= '0;
                for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
            end else if (w_exec) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (w_on) begin
                        if (w_tgt == IDX_W'(i)) begin
                            r_active[i] <= 1'b1;
                            r_note[i]   <= r_d1;
                            r_vel[i]    <= i_byte_data[6:0];
                            r_age[i]    <= '0;
                        end else if (r_active[i] && (r_age[i] != AGE_MAX)) begin
                            r_age[i] <= r_age[i] + 1'b1;
                        end
                    end else if (w_hits[i]) begin
                        r_active[i] <= 1'b0;
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_pack
            assign o_voice_note[7*gi +: 7] = r_note[gi];
            assign o_voice_vel[7*gi +: 7]  = r_vel[gi];
        end
    endgenerate

    assign o_voice_active = r_active;
    assign o_note_event   = r_note_event;
    assign o_steal        = r_steal;
endmodule

// File: tb/tb_midi_voice_scheduler.sv
// Randomized scoreboard bench: two schedulers (channel 0 only, and OMNI) share one
// byte stream; a reference model predicts each note event and the voice table.
module tb_midi_voice_scheduler;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          bv;
    logic [7:0]    bd;
    logic          panic;
    logic [N-1:0]  act0, act1;
    logic [7*N-1:0] note0, vel0, note1, vel1;
    logic          ev0, ev1, st0, st1;

    always #5 clk = ~clk;

    midi_voice_scheduler #(.NUM_VOICES(N), .CHANNEL(0), .OMNI(0), .AGE_W(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_byte_valid(bv), .i_byte_data(bd), .i_panic(panic),
        .o_voice_active(act0), .o_voice_note(note0), .o_voice_vel(vel0),
        .o_note_event(ev0), .o_steal(st0));

    midi_voice_scheduler #(.NUM_VOICES(N), .CHANNEL(0), .OMNI(1), .AGE_W(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_byte_valid(bv), .i_byte_data(bd), .i_panic(panic),
        .o_voice_active(act1), .o_voice_note(note1), .o_voice_vel(vel1),
        .o_note_event(ev1), .o_steal(st1));

    typedef struct packed {
        logic [N-1:0]   act;
        logic [7*N-1:0] note;
        logic [7*N-1:0] vel;
        logic           steal;
    } snap_t;

    snap_t q0[$];
    snap_t q1[$];
    int total = 0;
    int bad   = 0;

    // Reference model: running status as "last status or -1", pending first data byte or -1.
    int p_status = -1;
    int p_d1     = -1;
    int m_act  [2][N];
    int m_note [2][N];
    int m_vel  [2][N];
    int m_age  [2][N];

    function automatic snap_t snap(int m, bit stl);
        snap_t s;
        for (int i = 0; i < N; i++) begin
            s.act[i]        = (m_act[m][i] != 0);
            s.note[7*i +: 7] = 7'(m_note[m][i]);
            s.vel[7*i +: 7]  = 7'(m_vel[m][i]);
        end
        s.steal = stl;
        return s;
    endfunction

    function automatic void model_reset();
        p_status = -1;
        p_d1     = -1;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < N; i++) begin
                m_act[m][i] = 0; m_note[m][i] = 0; m_vel[m][i] = 0; m_age[m][i] = 0;
            end
    endfunction

    function automatic void model_exec(int m, int s, int d1, int d2);
        int tgt;
        bit stl;
        int kind = s >> 4;
        if (!((kind == 8 || kind == 9) && (m == 1 || (s & 15) == 0))) return;
        stl = 1'b0;
        if (kind == 9 && d2 != 0) begin
            tgt = -1;
            for (int i = 0; i < N; i++)
                if (tgt < 0 && m_act[m][i] != 0 && m_note[m][i] == d1) tgt = i;
            for (int i = 0; i < N; i++)
                if (tgt < 0 && m_act[m][i] == 0) tgt = i;
            if (tgt < 0) begin
                stl = 1'b1;
                tgt = 0;
                for (int i = 1; i < N; i++)
                    if (m_age[m][i] > m_age[m][tgt]) tgt = i;
            end
            for (int i = 0; i < N; i++)
                if (i != tgt && m_act[m][i] != 0) m_age[m][i] = (m_age[m][i] >= 15) ? 15 : m_age[m][i] + 1;
            m_act[m][tgt] = 1; m_note[m][tgt] = d1; m_vel[m][tgt] = d2; m_age[m][tgt] = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (m_act[m][i] != 0 && m_note[m][i] == d1) m_act[m][i] = 0;
        end
        if (m == 0) q0.push_back(snap(0, stl));
        else        q1.push_back(snap(1, stl));
    endfunction

    function automatic void model_step(bit valid, int b, bit pan);
        if (valid) begin
            if (b >= 'hF8) begin
                p_status = p_status;
            end else if (b >= 'hF0) begin
                p_status = -1; p_d1 = -1;
            end else if (b >= 'h80) begin
                p_status = b; p_d1 = -1;
            end else if (p_status >= 0) begin
                if (p_d1 < 0) begin
                    if ((p_status >> 4) != 'hC && (p_status >> 4) != 'hD) p_d1 = b;
                end else begin
                    if (!pan) begin
                        model_exec(0, p_status, p_d1, b);
                        model_exec(1, p_status, p_d1, b);
                    end
                    p_d1 = -1;
                end
            end
        end
        if (pan)
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < N; i++) begin
                    m_act[m][i] = 0; m_age[m][i] = 0;
                end
    endfunction

    task automatic send(input logic [7:0] b, input logic pan = 1'b0);
        @(negedge clk);
        bv = 1'b1; bd = b; panic = pan;
        model_step(1'b1, int'(b), pan);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bv = 1'b0; panic = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bv = 1'b0; panic = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_state(input string name);
        snap_t e0, e1;
        e0 = snap(0, 1'b0);
        e1 = snap(1, 1'b0);
        total++;
        if (act0 !== e0.act || note0 !== e0.note || vel0 !== e0.vel) begin
            bad++;
            $display("FAIL %s ch0: act=%b note=%h vel=%h expected act=%b note=%h vel=%h",
                     name, act0, note0, vel0, e0.act, e0.note, e0.vel);
        end
        total++;
        if (act1 !== e1.act || note1 !== e1.note || vel1 !== e1.vel) begin
            bad++;
            $display("FAIL %s omni: act=%b note=%h vel=%h expected act=%b note=%h vel=%h",
                     name, act1, note1, vel1, e1.act, e1.note, e1.vel);
        end
    endtask

    task automatic chk_event(input int m, input snap_t got);
        snap_t exp;
        total++;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL event dut%0d: unexpected note_event act=%b steal=%b expected no event", m, got.act, got.steal);
            return;
        end
        exp = (m == 0) ? q0.pop_front() : q1.pop_front();
        if (got !== exp) begin
            bad++;
            $display("FAIL event dut%0d: act=%b note=%h vel=%h steal=%b expected act=%b note=%h vel=%h steal=%b",
                     m, got.act, got.note, got.vel, got.steal, exp.act, exp.note, exp.vel, exp.steal);
        end else begin
            $display("event dut%0d ok: act=%b note=%h vel=%h steal=%b", m, got.act, got.note, got.vel, got.steal);
        end
    endtask

    // Monitor: samples just after each rising edge, independent of the stimulus thread.
    always @(posedge clk) begin
        #1;
        if (ev0) chk_event(0, {act0, note0, vel0, st0});
        else if (st0) begin total++; bad++; $display("FAIL steal dut0: steal=1 expected 0 without note_event"); end
        if (ev1) chk_event(1, {act1, note1, vel1, st1});
        else if (st1) begin total++; bad++; $display("FAIL steal dut1: steal=1 expected 0 without note_event"); end
    end

    initial begin
        logic [7:0] b;
        int r;
        rst = 1'b1; bv = 1'b0; bd = 8'h00; panic = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (act0 !== '0 || note0 !== '0 || vel0 !== '0 || ev0 !== 1'b0 || st0 !== 1'b0) begin
            bad++;
            $display("FAIL reset: act=%b note=%h vel=%h ev=%b steal=%b expected all zero", act0, note0, vel0, ev0, st0);
        end
        check_state("reset");

        send(8'h90); send(8'h3C); send(8'h40); idle(1);
        check_state("note_on_basic");
        send(8'h3E); send(8'h50); send(8'h80); send(8'h3C); send(8'h00); idle(1);
        check_state("running_status_off");

        idle(1); send(8'h00, 1'b1); idle(1);
        send(8'h90);
        for (int k = 0; k < 5; k++) begin send(8'(8'h30 + k)); send(8'h10); end
        idle(2);
        check_state("steal_oldest");

        send(8'h00, 1'b1); idle(1);
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h40); idle(1);
        check_state("realtime_mid_message");
        send(8'h90); send(8'h3C); send(8'h00); idle(1);
        check_state("vel_zero_off");

        send(8'h91); send(8'h3C); send(8'h40); idle(1);
        check_state("channel_filter");

        send(8'h00, 1'b1); idle(1);
        send(8'h90);
        for (int k = 0; k < 4; k++) begin send(8'(8'h50 + k)); send(8'h20); end
        send(8'h90); send(8'h40); send(8'h40, 1'b1); idle(1);
        check_state("panic_with_execute");
        send(8'h90); send(8'h3C); do_reset(); send(8'h40); idle(1);
        check_state("reset_mid_message");

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 10)       b = 8'h90;
            else if (r < 14)  b = 8'h80;
            else if (r < 17)  b = 8'h91;
            else if (r < 19)  b = 8'hC0;
            else if (r < 20)  b = 8'hB0;
            else if (r < 21)  b = 8'hF0;
            else if (r < 23)  b = 8'hF8;
            else if (r < 28)  b = 8'h00;
            else if (r < 45)  b = 8'($urandom_range(0, 127));
            else              b = 8'(8'h30 + $urandom_range(0, 9));
            send(b, ($urandom_range(0, 99) < 2));
            if ($urandom_range(0, 99) < 25) idle($urandom_range(1, 3));
            if (n % 100 == 99) begin idle(1); check_state("random_state"); end
        end
        idle(2);
        check_state("random_final");

        total++;
        if (q0.size() != 0) begin bad++; $display("FAIL pending dut0: %0d events missing expected 0", q0.size()); end
        total++;
        if (q1.size() != 0) begin bad++; $display("FAIL pending dut1: %0d events missing expected 0", q1.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
